// File: rtl/temporal_diff_stream.sv
// Streaming temporal-gradient stage: emits It = curr - prev with (x,y) tags
// and reports per-frame motion count, bounding box and pixel-count integrity.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   pixel_curr/prev       co-located pixel pair, qualified by pixel_valid
//   frame_done            producer end-of-frame (ignored outside a frame)
//   it_out/it_x/it_y      signed gradient and its raster position (it_valid)
//   stats_valid           one-cycle pulse when the statistics below update
//   pixel_count           pixels accepted in the last frame
//   motion_count          pixels with |It| >= DIFF_THRESHOLD
//   bbox_*                inclusive motion bounding box, bbox_valid if any
//   frame_error           short frame or overrun
module temporal_diff_stream #(
  parameter int PIXEL_WIDTH    = 8,
  parameter int IMAGE_WIDTH    = 320,
  parameter int IMAGE_HEIGHT   = 240,
  parameter int DIFF_THRESHOLD = 32,
  localparam int XW = $clog2(IMAGE_WIDTH),
  localparam int YW = $clog2(IMAGE_HEIGHT),
  localparam int CW = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT + 1),
  localparam int DW = PIXEL_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PIXEL_WIDTH-1:0] pixel_curr,
  input  logic [PIXEL_WIDTH-1:0] pixel_prev,
  input  logic                   pixel_valid,
  input  logic                   frame_done,
  output logic [DW-1:0]          it_out,
  output logic [XW-1:0]          it_x,
  output logic [YW-1:0]          it_y,
  output logic                   it_valid,
  output logic                   stats_valid,
  output logic [CW-1:0]          pixel_count,
  output logic [CW-1:0]          motion_count,
  output logic [XW-1:0]          bbox_x_min,
  output logic [XW-1:0]          bbox_x_max,
  output logic [YW-1:0]          bbox_y_min,
  output logic [YW-1:0]          bbox_y_max,
  output logic                   bbox_valid,
  output logic                   frame_error
);

  localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [CW-1:0] TOTAL  = CW'(NPIX);
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
  localparam logic [DW-1:0] THR    = DW'(DIFF_THRESHOLD);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REPORT
  } state_t;

  state_t state_q, state_d;

  // working (per-frame) state
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] mcnt_q, mcnt_d;
  logic          ovr_q, ovr_d;
  logic [XW-1:0] wx_min_q, wx_min_d;
  logic [XW-1:0] wx_max_q, wx_max_d;
  logic [YW-1:0] wy_min_q, wy_min_d;
  logic [YW-1:0] wy_max_q, wy_max_d;

  // registered outputs
  logic [DW-1:0] it_out_q, it_out_d;
  logic [XW-1:0] it_x_q, it_x_d;
  logic [YW-1:0] it_y_q, it_y_d;
  logic          it_valid_q, it_valid_d;
  logic          stats_valid_q, stats_valid_d;
  logic [CW-1:0] pixel_count_q, pixel_count_d;
  logic [CW-1:0] motion_count_q, motion_count_d;
  logic [XW-1:0] bbox_x_min_q, bbox_x_min_d;
  logic [XW-1:0] bbox_x_max_q, bbox_x_max_d;
  logic [YW-1:0] bbox_y_min_q, bbox_y_min_d;
  logic [YW-1:0] bbox_y_max_q, bbox_y_max_d;
  logic          bbox_valid_q, bbox_valid_d;
  logic          frame_error_q, frame_error_d;

  // datapath
  logic [DW-1:0] diff;
  logic [DW-1:0] mag;
  logic          is_motion;

  assign diff = {1'b0, pixel_curr} - {1'b0, pixel_prev};
  assign mag  = diff[DW-1] ? (~diff + DW'(1)) : diff;
  assign is_motion = (mag >= THR);

  // A pixel outside RUN opens a new frame: working state reads as cleared.
  logic          start;
  logic          accept;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [CW-1:0] cb;
  logic [CW-1:0] mb;
  logic          ob;
  logic [XW-1:0] bx_min, bx_max;
  logic [YW-1:0] by_min, by_max;

  assign start  = pixel_valid && (state_q != RUN);
  assign px     = start ? '0 : x_q;
  assign py     = start ? '0 : y_q;
  assign cb     = start ? '0 : cnt_q;
  assign mb     = start ? '0 : mcnt_q;
  assign ob     = start ? 1'b0 : ovr_q;
  assign bx_min = start ? '0 : wx_min_q;
  assign bx_max = start ? '0 : wx_max_q;
  assign by_min = start ? '0 : wy_min_q;
  assign by_max = start ? '0 : wy_max_q;
  assign accept = pixel_valid && (cb != TOTAL);

  logic finalize;

  always_comb begin
    state_d        = state_q;
    x_d            = px;
    y_d            = py;
    cnt_d          = cb;
    mcnt_d         = mb;
    ovr_d          = ob;
    wx_min_d       = bx_min;
    wx_max_d       = bx_max;
    wy_min_d       = by_min;
    wy_max_d       = by_max;
    it_out_d       = it_out_q;
    it_x_d         = it_x_q;
    it_y_d         = it_y_q;
    it_valid_d     = 1'b0;
    stats_valid_d  = 1'b0;
    pixel_count_d  = pixel_count_q;
    motion_count_d = motion_count_q;
    bbox_x_min_d   = bbox_x_min_q;
    bbox_x_max_d   = bbox_x_max_q;
    bbox_y_min_d   = bbox_y_min_q;
    bbox_y_max_d   = bbox_y_max_q;
    bbox_valid_d   = bbox_valid_q;
    frame_error_d  = frame_error_q;
    finalize       = 1'b0;

    if (accept) begin
      it_out_d   = diff;
      it_x_d     = px;
      it_y_d     = py;
      it_valid_d = 1'b1;
      cnt_d      = cb + CW'(1);
      if (px == X_LAST) begin
        x_d = '0;
        // row stays pinned on the last line
        if (py != Y_LAST) begin
          y_d = py + YW'(1);
        end
      end else begin
        x_d = px + XW'(1);
      end
      if (is_motion) begin
        mcnt_d = mb + CW'(1);
        if (mb == '0) begin
          wx_min_d = px;
          wx_max_d = px;
          wy_min_d = py;
          wy_max_d = py;
        end else begin
          if (px < bx_min) wx_min_d = px;
          if (px > bx_max) wx_max_d = px;
          if (py < by_min) wy_min_d = py;
          if (py > by_max) wy_max_d = py;
        end
      end
    end else if (pixel_valid) begin
      ovr_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (pixel_valid) state_d = RUN;
      end
      RUN: begin
        if (frame_done) begin
          state_d  = REPORT;
          finalize = 1'b1;
        end
      end
      REPORT: begin
        state_d = pixel_valid ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // snapshot includes a pixel arriving with frame_done
    if (finalize) begin
      stats_valid_d  = 1'b1;
      pixel_count_d  = cnt_d;
      motion_count_d = mcnt_d;
      bbox_valid_d   = (mcnt_d != '0);
      frame_error_d  = ovr_d || (cnt_d != TOTAL);
      if (mcnt_d != '0) begin
        bbox_x_min_d = wx_min_d;
        bbox_x_max_d = wx_max_d;
        bbox_y_min_d = wy_min_d;
        bbox_y_max_d = wy_max_d;
      end else begin
        bbox_x_min_d = '0;
        bbox_x_max_d = '0;
        bbox_y_min_d = '0;
        bbox_y_max_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      x_q            <= '0;
      y_q            <= '0;
      cnt_q          <= '0;
      mcnt_q         <= '0;
      ovr_q          <= 1'b0;
      wx_min_q       <= '0;
      wx_max_q       <= '0;
      wy_min_q       <= '0;
      wy_max_q       <= '0;
      it_out_q       <= '0;
      it_x_q         <= '0;
      it_y_q         <= '0;
      it_valid_q     <= 1'b0;
      stats_valid_q  <= 1'b0;
      pixel_count_q  <= '0;
      motion_count_q <= '0;
      bbox_x_min_q   <= '0;
      bbox_x_max_q   <= '0;
      bbox_y_min_q   <= '0;
      bbox_y_max_q   <= '0;
      bbox_valid_q   <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      cnt_q          <= cnt_d;
      mcnt_q         <= mcnt_d;
      ovr_q          <= ovr_d;
      wx_min_q       <= wx_min_d;
      wx_max_q       <= wx_max_d;
      wy_min_q       <= wy_min_d;
      wy_max_q       <= wy_max_d;
      it_out_q       <= it_out_d;
      it_x_q         <= it_x_d;
      it_y_q         <= it_y_d;
      it_valid_q     <= it_valid_d;
      stats_valid_q  <= stats_valid_d;
      pixel_count_q  <= pixel_count_d;
      motion_count_q <= motion_count_d;
      bbox_x_min_q   <= bbox_x_min_d;
      bbox_x_max_q   <= bbox_x_max_d;
      bbox_y_min_q   <= bbox_y_min_d;
      bbox_y_max_q   <= bbox_y_max_d;
      bbox_valid_q   <= bbox_valid_d;
      frame_error_q  <= frame_error_d;
    end
  end

  assign it_out       = it_out_q;
  assign it_x         = it_x_q;
  assign it_y         = it_y_q;
  assign it_valid     = it_valid_q;
  assign stats_valid  = stats_valid_q;
  assign pixel_count  = pixel_count_q;
  assign motion_count = motion_count_q;
  assign bbox_x_min   = bbox_x_min_q;
  assign bbox_x_max   = bbox_x_max_q;
  assign bbox_y_min   = bbox_y_min_q;
  assign bbox_y_max   = bbox_y_max_q;
  assign bbox_valid   = bbox_valid_q;
  assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_temporal_diff_stream.sv
// Bench for temporal_diff_stream on a reduced 40x30 image: random and
// directed frames checked cycle-by-cycle against a frame-array model.
module tb_temporal_diff_stream;

  localparam int W  = 40;
  localparam int H  = 30;
  localparam int N  = W * H;
  localparam int TH = 32;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    pixel_curr = '0;
  logic [7:0]    pixel_prev = '0;
  logic          pixel_valid = 1'b0;
  logic          frame_done = 1'b0;
  logic [8:0]    it_out;
  logic [XW-1:0] it_x;
  logic [YW-1:0] it_y;
  logic          it_valid;
  logic          stats_valid;
  logic [CW-1:0] pixel_count;
  logic [CW-1:0] motion_count;
  logic [XW-1:0] bbox_x_min;
  logic [XW-1:0] bbox_x_max;
  logic [YW-1:0] bbox_y_min;
  logic [YW-1:0] bbox_y_max;
  logic          bbox_valid;
  logic          frame_error;

  temporal_diff_stream #(
    .PIXEL_WIDTH   (8),
    .IMAGE_WIDTH   (W),
    .IMAGE_HEIGHT  (H),
    .DIFF_THRESHOLD(TH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_curr  (pixel_curr),
    .pixel_prev  (pixel_prev),
    .pixel_valid (pixel_valid),
    .frame_done  (frame_done),
    .it_out      (it_out),
    .it_x        (it_x),
    .it_y        (it_y),
    .it_valid    (it_valid),
    .stats_valid (stats_valid),
    .pixel_count (pixel_count),
    .motion_count(motion_count),
    .bbox_x_min  (bbox_x_min),
    .bbox_x_max  (bbox_x_max),
    .bbox_y_min  (bbox_y_min),
    .bbox_y_max  (bbox_y_max),
    .bbox_valid  (bbox_valid),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // reference model: whole-frame array of differences
  bit in_frame = 0;
  bit ovr = 0;
  int k = 0;
  int dif [N];
  int e_pc, e_mc, e_xmin, e_xmax, e_ymin, e_ymax;
  bit e_bv, e_fe;
  int n_stats = 0;
  int obs_it [N];
  int obs_x [N];
  int obs_y [N];

  task automatic model_report();
    int m;
    e_pc = k;
    e_mc = 0;
    e_xmin = W; e_xmax = -1;
    e_ymin = H; e_ymax = -1;
    for (int i = 0; i < k; i++) begin
      m = dif[i] < 0 ? -dif[i] : dif[i];
      if (m >= TH) begin
        e_mc++;
        if (i % W < e_xmin) e_xmin = i % W;
        if (i % W > e_xmax) e_xmax = i % W;
        if (i / W < e_ymin) e_ymin = i / W;
        if (i / W > e_ymax) e_ymax = i / W;
      end
    end
    e_bv = (e_mc != 0);
    if (!e_bv) begin
      e_xmin = 0; e_xmax = 0;
      e_ymin = 0; e_ymax = 0;
    end
    e_fe = ovr || (k != N);
  endtask

  task automatic step(input bit v, input int c, input int p,
                      input bit d);
    bit ev, es, was;
    int eit, ex, ey, idx;
    pixel_valid = v;
    pixel_curr  = c[7:0];
    pixel_prev  = p[7:0];
    frame_done  = d;
    @(posedge clk);
    ev = 0; es = 0; eit = 0; ex = 0; ey = 0; idx = 0;
    was = in_frame;
    if (v) begin
      if (!in_frame) begin
        in_frame = 1; k = 0; ovr = 0;
      end
      if (k < N) begin
        dif[k] = c - p;
        eit = c - p; ex = k % W; ey = k / W;
        idx = k;
        ev = 1; k++;
      end else begin
        ovr = 1;
      end
    end
    if (was && d) begin
      model_report();
      es = 1;
      in_frame = 0;
    end
    #1;
    chk("it_valid", int'(it_valid), int'(ev));
    if (ev) begin
      chk("it_out", int'($signed(it_out)), eit);
      chk("it_x", int'(it_x), ex);
      chk("it_y", int'(it_y), ey);
      obs_it[idx] = int'($signed(it_out));
      obs_x[idx]  = int'(it_x);
      obs_y[idx]  = int'(it_y);
    end
    chk("stats_valid", int'(stats_valid), int'(es));
    if (stats_valid) n_stats++;
    if (es) begin
      chk("pixel_count", int'(pixel_count), e_pc);
      chk("motion_count", int'(motion_count), e_mc);
      chk("bbox_x_min", int'(bbox_x_min), e_xmin);
      chk("bbox_x_max", int'(bbox_x_max), e_xmax);
      chk("bbox_y_min", int'(bbox_y_min), e_ymin);
      chk("bbox_y_max", int'(bbox_y_max), e_ymax);
      chk("bbox_valid", int'(bbox_valid), int'(e_bv));
      chk("frame_error", int'(frame_error), int'(e_fe));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pixel_valid = 1'b0;
    frame_done = 1'b0;
    @(posedge clk);
    #1;
    in_frame = 0;
    chk("rst_it_valid", int'(it_valid), 0);
    chk("rst_stats_valid", int'(stats_valid), 0);
    chk("rst_it_out", int'(it_out), 0);
    chk("rst_it_xy", int'(it_x) + int'(it_y), 0);
    chk("rst_pixel_count", int'(pixel_count), 0);
    chk("rst_motion_count", int'(motion_count), 0);
    chk("rst_bbox", int'(bbox_x_min) + int'(bbox_x_max)
        + int'(bbox_y_min) + int'(bbox_y_max), 0);
    chk("rst_bbox_valid", int'(bbox_valid), 0);
    chk("rst_frame_error", int'(frame_error), 0);
    rst_n = 1'b1;
  endtask

  // mode 0: curr=prev, 1: shifted square, 2: random pairs
  task automatic gen(input int i, input int mode,
                     output int c, output int p);
    int x, y;
    x = i % W;
    y = i / W;
    c = 0; p = 0;
    if (mode == 0) begin
      c = $urandom_range(255);
      p = c;
    end else if (mode == 1) begin
      c = (x >= 10 && x <= 17 && y >= 5 && y <= 12) ? 255 : 0;
      p = (x >= 8 && x <= 15 && y >= 5 && y <= 12) ? 255 : 0;
    end else begin
      c = $urandom_range(255);
      p = $urandom_range(255);
    end
  endtask

  // done_mode 0: separate frame_done cycle, 1: with last pixel, 2: none
  task automatic frame(input int npix, input int mode,
                       input int done_mode, input bit gaps);
    int c, p;
    for (int i = 0; i < npix; i++) begin
      gen(i, mode, c, p);
      if (gaps && $urandom_range(3) == 0) begin
        step(0, $urandom_range(255), $urandom_range(255), 0);
      end
      step(1, c, p, done_mode == 1 && i == npix - 1);
    end
    if (done_mode == 0) step(0, 0, 0, 1);
  endtask

  initial begin
    do_reset();

    // identical frames
    n_stats = 0;
    frame(N, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("id_motion", int'(motion_count), 0);
    chk("id_bbox_valid", int'(bbox_valid), 0);
    chk("id_bbox_x_max", int'(bbox_x_max), 0);
    chk("id_pixel_count", int'(pixel_count), N);
    chk("id_frame_error", int'(frame_error), 0);
    chk("id_stats_pulses", n_stats, 1);

    // shifted square
    frame(N, 1, 0, 0);
    chk("sq_motion", int'(motion_count), 32);
    chk("sq_x_min", int'(bbox_x_min), 8);
    chk("sq_x_max", int'(bbox_x_max), 17);
    chk("sq_y_min", int'(bbox_y_min), 5);
    chk("sq_y_max", int'(bbox_y_max), 12);
    chk("sq_it_neg", obs_it[5 * W + 8], -255);
    chk("sq_it_pos", obs_it[12 * W + 17], 255);

    // random frame with gaps, done alongside last pixel
    frame(N, 2, 1, 1);
    step(0, 0, 0, 0);
    chk("xy_wrap_x", obs_x[W], 0);
    chk("xy_wrap_y", obs_y[W], 1);
    chk("xy_last_x", obs_x[N - 1], W - 1);
    chk("xy_last_y", obs_y[N - 1], H - 1);

    // threshold boundary on lone pairs
    step(1, 40, 8, 1);
    step(0, 0, 0, 1);
    chk("thr32_motion", int'(motion_count), 1);
    chk("thr32_bbox_valid", int'(bbox_valid), 1);
    step(1, 40, 9, 0);
    step(0, 0, 0, 1);
    chk("thr31_motion", int'(motion_count), 0);
    chk("thr31_bbox_valid", int'(bbox_valid), 0);

    // short frame then full frame
    frame(100, 2, 0, 1);
    chk("short_count", int'(pixel_count), 100);
    chk("short_error", int'(frame_error), 1);
    frame(N, 0, 0, 0);
    chk("after_short_error", int'(frame_error), 0);

    // overrun by one non-zero-diff pixel
    frame(N, 0, 2, 0);
    step(1, 200, 10, 0);
    step(0, 0, 0, 1);
    chk("ovr_count", int'(pixel_count), N);
    chk("ovr_error", int'(frame_error), 1);
    chk("ovr_motion", int'(motion_count), 0);

    // reset mid-frame
    n_stats = 0;
    frame(500, 2, 2, 0);
    do_reset();
    step(0, 0, 0, 1);
    chk("rst_mid_pulses", n_stats, 0);
    frame(N, 2, 0, 1);
    chk("rst_next_count", int'(pixel_count), N);
    chk("rst_next_error", int'(frame_error), 0);

    // back-to-back: next pixel 0 lands in the report cycle
    frame(N, 2, 1, 0);
    chk("b2b_a_count", int'(pixel_count), N);
    frame(N, 2, 1, 0);
    chk("b2b_b_count", int'(pixel_count), N);
    chk("b2b_b_error", int'(frame_error), 0);
    step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
